datapath_sequencer: RTL and testbench

DATAPATH_SEQUENCER -- requirements
Module: datapath_sequencer

---
 rtl/datapath_sequencer.sv | 172 +++++++++++++++++
 tb/tb_datapath_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_sequencer.sv
// datapath_sequencer: fetch / decode / execute / writeback controller for a
// simple register-file + ALU datapath with single-step support.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a start edge, outputs quiet
// FETCH  | pc presented to instruction memory for one cycle
// DECODE | instruction word valid, latched into IR
// EXEC   | operands/function driven, flags captured for ALU classes
// WB     | register write (class 00), pc and instr_count advance
// PAUSE  | single-step hold, waits for a step edge or step_mode low
// HALT   | HALT instruction reached, pc parked on its address
module datapath_sequencer #(
  parameter int PC_W = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            step_mode,
  input  logic            step,
  input  logic [23:0]     instr,
  input  logic            alu_zero,
  input  logic            alu_cout,
  output logic [PC_W-1:0] pc,
  output logic [3:0]      ra,
  output logic [3:0]      rb,
  output logic [3:0]      wa,
  output logic            we,
  output logic [4:0]      alu_func,
  output logic            alu_cin,
  output logic            zflag,
  output logic            cflag,
  output logic            busy,
  output logic            halted,
  output logic [15:0]     instr_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_PAUSE, S_HALT
  } state_t;

  localparam logic [1:0] CLS_ALU = 2'b00;
  localparam logic [1:0] CLS_BRZ = 2'b10;
  localparam logic [1:0] CLS_HALT = 2'b11;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [23:0]     ir_q, ir_d;
  logic            zflag_q, zflag_d, cflag_q, cflag_d;
  logic [15:0]     count_q, count_d;
  logic            start_hist_q, start_hist_d, step_hist_q, step_hist_d;
  logic            busy_q, busy_d, halted_q, halted_d;
  logic            we_q, we_d, alu_cin_q, alu_cin_d;
  logic [3:0]      ra_q, ra_d, rb_q, rb_d, wa_q, wa_d;
  logic [4:0]      alu_func_q, alu_func_d;
  logic            start_edge, step_edge, exec_wb;

  // Next-state, datapath-register and registered-output computation.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    zflag_d      = zflag_q;
    cflag_d      = cflag_q;
    count_d      = count_q;
    start_hist_d = start;
    step_hist_d  = step;
    start_edge   = start & ~start_hist_q;
    step_edge    = step & ~step_hist_q;

    case (state_q)
      S_IDLE, S_HALT: begin
        if (start_edge) begin
          state_d = S_FETCH;
          pc_d    = '0;
          zflag_d = 1'b0;
          cflag_d = 1'b0;
          count_d = 16'd0;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        ir_d    = instr;
        state_d = (instr[23:22] == CLS_HALT) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        // classes 00 and 01 both have bit 23 clear
        if (!ir_q[23]) begin
          zflag_d = alu_zero;
          cflag_d = alu_cout;
        end
        state_d = S_WB;
      end
      S_WB: begin
        if (ir_q[23:22] == CLS_BRZ && zflag_q) pc_d = ir_q[PC_W-1:0];
        else                                   pc_d = pc_q + PC_W'(1);
        if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
        state_d = step_mode ? S_PAUSE : S_FETCH;
      end
      S_PAUSE: begin
        if (step_edge || !step_mode) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are derived from the state being entered so they register
    // cleanly and stay constant for the whole EXEC/WB pair.
    exec_wb    = (state_d == S_EXEC) || (state_d == S_WB);
    busy_d     = (state_d != S_IDLE) && (state_d != S_HALT);
    halted_d   = (state_d == S_HALT);
    ra_d       = exec_wb ? ir_d[11:8]  : 4'd0;
    rb_d       = exec_wb ? ir_d[7:4]   : 4'd0;
    alu_func_d = exec_wb ? ir_d[21:17] : 5'd0;
    alu_cin_d  = exec_wb ? ir_d[16]    : 1'b0;
    we_d       = (state_d == S_WB) && (ir_d[23:22] == CLS_ALU);
    wa_d       = we_d ? ir_d[15:12] : 4'd0;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      ir_q         <= 24'd0;
      zflag_q      <= 1'b0;
      cflag_q      <= 1'b0;
      count_q      <= 16'd0;
      start_hist_q <= 1'b0;
      step_hist_q  <= 1'b0;
      busy_q       <= 1'b0;
      halted_q     <= 1'b0;
      we_q         <= 1'b0;
      wa_q         <= 4'd0;
      ra_q         <= 4'd0;
      rb_q         <= 4'd0;
      alu_func_q   <= 5'd0;
      alu_cin_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      zflag_q      <= zflag_d;
      cflag_q      <= cflag_d;
      count_q      <= count_d;
      start_hist_q <= start_hist_d;
      step_hist_q  <= step_hist_d;
      busy_q       <= busy_d;
      halted_q     <= halted_d;
      we_q         <= we_d;
      wa_q         <= wa_d;
      ra_q         <= ra_d;
      rb_q         <= rb_d;
      alu_func_q   <= alu_func_d;
      alu_cin_q    <= alu_cin_d;
    end
  end

  // A reset raised during WB must kill the write already on the port.
  assign we          = we_q & ~reset;
  assign pc          = pc_q;
  assign wa          = wa_q;
  assign ra          = ra_q;
  assign rb          = rb_q;
  assign alu_func    = alu_func_q;
  assign alu_cin     = alu_cin_q;
  assign zflag       = zflag_q;
  assign cflag       = cflag_q;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed self-checking bench for datapath_sequencer: a table of short
// programs plus hand-written sequences for timing, stepping, wrap and reset.
module tb_datapath_sequencer;

  logic        clock = 1'b0;
  logic        reset, start, step_mode, step;
  logic [23:0] instr;
  logic        alu_zero, alu_cout;
  logic [7:0]  pc;
  logic [3:0]  ra, rb, wa;
  logic        we;
  logic [4:0]  alu_func;
  logic        alu_cin, zflag, cflag, busy, halted;
  logic [15:0] instr_count;

  int checks = 0;
  int errors = 0;

  logic [23:0] mem [256];
  logic        az0, cz0, az1, cz1;
  int          we_cnt;
  logic [3:0]  last_wa;

  localparam logic [23:0] HALT_I = 24'hC00000;

  datapath_sequencer #(.PC_W(8)) dut (
    .clock(clock), .reset(reset), .start(start), .step_mode(step_mode),
    .step(step), .instr(instr), .alu_zero(alu_zero), .alu_cout(alu_cout),
    .pc(pc), .ra(ra), .rb(rb), .wa(wa), .we(we), .alu_func(alu_func),
    .alu_cin(alu_cin), .zflag(zflag), .cflag(cflag), .busy(busy),
    .halted(halted), .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  // synchronous instruction memory: data valid one cycle after pc
  always @(posedge clock) instr <= mem[pc];

  // ALU stand-in: result flags chosen per program slot
  assign alu_zero = (pc == 8'h00) ? az0 : az1;
  assign alu_cout = (pc == 8'h00) ? cz0 : cz1;

  always @(negedge clock) begin
    if (we) begin
      we_cnt  = we_cnt + 1;
      last_wa = wa;
    end
  end

  typedef struct {
    logic [23:0] i0;
    logic [23:0] i1;
    logic        az0, cz0, az1, cz1;
    int          we_n;
    int          wa_e;
    int          z_e, c_e;
    int          pc_e;
    int          cnt_e;
  } vec_t;

  function automatic logic [23:0] mk_alu(logic [1:0] cls, logic [4:0] f, logic cin,
                                         logic [3:0] w, logic [3:0] a, logic [3:0] b);
    return {cls, f, cin, w, a, b, 4'h0};
  endfunction

  function automatic logic [23:0] mk_brz(logic [7:0] t);
    return {2'b10, 14'h0, t};
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fill_halt();
    for (int i = 0; i < 256; i++) mem[i] = HALT_I;
  endtask

  task automatic start_pulse();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
  endtask

  task automatic wait_halted(int max);
    int n = 0;
    while (!halted && n < max) begin
      @(negedge clock);
      n++;
    end
    check("halt_reached", int'(halted), 1);
  endtask

  task automatic check_quiet(string tag);
    check({tag, "_pc"}, int'(pc), 0);
    check({tag, "_we"}, int'(we), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_halted"}, int'(halted), 0);
    check({tag, "_cnt"}, int'(instr_count), 0);
    check({tag, "_flags"}, int'({zflag, cflag}), 0);
    check({tag, "_regs"}, int'({ra, rb, wa, alu_func, alu_cin}), 0);
  endtask

  vec_t vecs [7];

  initial begin
    int we_hits, we_cyc;
    logic [3:0] we_wa;
    int n;

    reset = 1'b1; start = 1'b0; step_mode = 1'b0; step = 1'b0;
    az0 = 0; cz0 = 0; az1 = 0; cz1 = 0; we_cnt = 0; last_wa = 0;
    fill_halt();

    // ---- reset state ----
    repeat (3) @(negedge clock);
    check_quiet("reset");
    reset = 1'b0;
    @(negedge clock);
    check_quiet("idle");

    // ---- ADD then HALT: write exactly in cycle 4 after the start edge ----
    fill_halt();
    mem[0] = mk_alu(2'b00, 5'h01, 1'b1, 4'd3, 4'd1, 4'd2);
    az0 = 0; cz0 = 0;
    we_hits = 0; we_cyc = 0; we_wa = 0;
    @(negedge clock); start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      start = 1'b0;
      if (c == 1) begin
        check("fetch_pc", int'(pc), 0);
        check("fetch_busy", int'(busy), 1);
      end
      if (we) begin
        we_hits++;
        we_cyc = c;
        we_wa  = wa;
      end
      if (c == 3 || c == 4) begin
        check("exwb_ra", int'(ra), 1);
        check("exwb_rb", int'(rb), 2);
        check("exwb_func", int'(alu_func), 1);
        check("exwb_cin", int'(alu_cin), 1);
      end
    end
    check("add_we_pulses", we_hits, 1);
    check("add_we_cycle", we_cyc, 4);
    check("add_we_wa", int'(we_wa), 3);
    check("add_halted", int'(halted), 1);
    check("add_busy", int'(busy), 0);
    check("add_cnt", int'(instr_count), 1);
    check("add_pc", int'(pc), 1);

    // ---- table of two-instruction programs, restarted from HALT ----
    //         i0                                        i1                 az0 cz0 az1 cz1 we wa z c pc    cnt
    vecs[0] = '{mk_alu(2'b00, 5'h01, 1'b0, 4'd3, 4'd1, 4'd2), HALT_I,       0, 1, 0, 0, 1, 3, 0, 1, 1,    1};
    vecs[1] = '{mk_alu(2'b01, 5'h02, 1'b0, 4'd4, 4'd1, 4'd1), mk_brz(8'h20), 1, 0, 0, 0, 0, 0, 1, 0, 8'h20, 2};
    vecs[2] = '{mk_brz(8'h30), mk_alu(2'b00, 5'h03, 1'b0, 4'd7, 4'd2, 4'd3), 0, 0, 1, 1, 1, 7, 1, 1, 2,    2};
    vecs[3] = '{HALT_I, HALT_I,                                              0, 0, 0, 0, 0, 0, 0, 0, 0,    0};
    vecs[4] = '{mk_alu(2'b00, 5'h04, 1'b1, 4'd6, 4'd5, 4'd4), mk_brz(8'h20), 0, 0, 1, 1, 1, 6, 0, 0, 2,    2};
    vecs[5] = '{mk_alu(2'b00, 5'h05, 1'b0, 4'd5, 4'd1, 4'd2),
                mk_alu(2'b01, 5'h06, 1'b0, 4'd9, 4'd3, 4'd4),               1, 1, 0, 1, 1, 5, 0, 1, 2,    2};
    vecs[6] = '{mk_alu(2'b01, 5'h07, 1'b0, 4'd0, 4'd1, 4'd2), mk_brz(8'h05), 1, 1, 0, 0, 0, 0, 1, 1, 5,    2};

    for (int v = 0; v < 7; v++) begin
      fill_halt();
      mem[0] = vecs[v].i0;
      mem[1] = vecs[v].i1;
      az0 = vecs[v].az0; cz0 = vecs[v].cz0;
      az1 = vecs[v].az1; cz1 = vecs[v].cz1;
      we_cnt = 0;
      start_pulse();
      check($sformatf("v%0d_restart_busy", v), int'(busy), 1);
      wait_halted(60);
      check($sformatf("v%0d_we_pulses", v), we_cnt, vecs[v].we_n);
      if (vecs[v].we_n > 0) check($sformatf("v%0d_wa", v), int'(last_wa), vecs[v].wa_e);
      check($sformatf("v%0d_zflag", v), int'(zflag), vecs[v].z_e);
      check($sformatf("v%0d_cflag", v), int'(cflag), vecs[v].c_e);
      check($sformatf("v%0d_pc", v), int'(pc), vecs[v].pc_e);
      check($sformatf("v%0d_cnt", v), int'(instr_count), vecs[v].cnt_e);
    end

    // ---- single step: a held step level advances exactly once ----
    fill_halt();
    for (int i = 0; i < 3; i++) mem[i] = mk_alu(2'b00, 5'h01, 1'b0, 4'(i + 1), 4'd1, 4'd2);
    az0 = 0; cz0 = 0; az1 = 0; cz1 = 0;
    step_mode = 1'b1;
    start_pulse();
    repeat (7) @(negedge clock);
    check("step_pause_busy", int'(busy), 1);
    check("step_pause_cnt", int'(instr_count), 1);
    check("step_pause_pc", int'(pc), 1);
    step = 1'b1;
    repeat (10) @(negedge clock);
    check("step_held_cnt", int'(instr_count), 2);
    check("step_held_pc", int'(pc), 2);
    step = 1'b0;
    repeat (2) @(negedge clock);
    step = 1'b1;
    repeat (2) @(negedge clock);
    step = 1'b0;
    repeat (8) @(negedge clock);
    check("step_second_cnt", int'(instr_count), 3);
    check("step_second_pc", int'(pc), 3);
    check("step_second_busy", int'(busy), 1);
    step_mode = 1'b0;
    repeat (8) @(negedge clock);
    check("step_release_halted", int'(halted), 1);
    check("step_release_cnt", int'(instr_count), 3);

    // ---- pc wrap: branch to 0xFF, ALU there, next pc is 0x00 ----
    fill_halt();
    mem[0]    = mk_alu(2'b01, 5'h02, 1'b0, 4'd0, 4'd1, 4'd1);
    mem[1]    = mk_brz(8'hFF);
    mem[8'hFF] = mk_alu(2'b00, 5'h03, 1'b0, 4'd2, 4'd1, 4'd1);
    az0 = 1; cz0 = 0; az1 = 0; cz1 = 0;
    start_pulse();
    n = 0;
    while (instr_count != 16'd3 && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("wrap_cnt", int'(instr_count), 3);
    check("wrap_pc", int'(pc), 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // ---- start edge while busy is ignored ----
    fill_halt();
    for (int i = 0; i < 3; i++) mem[i] = mk_alu(2'b00, 5'h01, 1'b0, 4'd1, 4'd1, 4'd2);
    az0 = 0; cz0 = 0;
    start_pulse();
    repeat (4) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    check("busy_start_pc", int'(pc), 1);
    check("busy_start_cnt", int'(instr_count), 1);
    start = 1'b0;
    wait_halted(60);
    check("busy_start_final_cnt", int'(instr_count), 3);
    check("busy_start_final_pc", int'(pc), 3);

    // ---- reset during WB suppresses the write ----
    fill_halt();
    mem[0] = mk_alu(2'b00, 5'h01, 1'b0, 4'd3, 4'd1, 4'd2);
    start_pulse();
    repeat (3) @(negedge clock);
    check("wb_we_before_reset", int'(we), 1);
    reset = 1'b1;
    #1;
    check("wb_we_during_reset", int'(we), 0);
    @(negedge clock);
    check_quiet("wbrst");
    reset = 1'b0;
    @(negedge clock);
    check("after_reset_we", int'(we), 0);
    we_cnt = 0;
    start_pulse();
    check("restart_pc", int'(pc), 0);
    check("restart_busy", int'(busy), 1);
    wait_halted(60);
    check("restart_cnt", int'(instr_count), 1);
    check("restart_pc_end", int'(pc), 1);
    check("restart_we_pulses", we_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
